// File: rtl/lcd_nibble_rx.sv
// Display-side responder for the 4-bit HD44780-style LCD bus: nibble reassembly, DDRAM address, busy flag, status reads.
// Optional half-byte timeout (TIMEOUT_CYCLES, timeout_err port) is built only when LCD_RX_TIMEOUT_EN is defined.
module lcd_nibble_rx #(
    parameter int BUSY_CYCLES = 40
`ifdef LCD_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [3:0] lcd_d_in,
    output logic [3:0] lcd_d_out,
    output logic       lcd_d_oe,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       busy,
    output logic [6:0] addr,
    output logic       nibble_phase
`ifdef LCD_RX_TIMEOUT_EN
    ,
    output logic       timeout_err
`endif
);

    localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);

    typedef enum logic {PH_HI = 1'b0, PH_LO = 1'b1} phase_t;

    phase_t            phase_q, phase_d;
    logic              en_q;
    logic              hold_rs, hold_rw;
    logic [3:0]        hold_d;
    logic              hi_rs, hi_rw;
    logic [3:0]        hi_d;
    logic              oe_q;
    logic [BUSY_W-1:0] busy_cnt;
    logic              fall, hi_load, byte_fire, timeout_hit;
    logic [7:0]        asm_byte;
    logic [6:0]        addr_nxt;

    // A transfer is the cycle in which enable drops; it uses values captured while enable was high.
    assign fall      = en_q & ~lcd_en;
    assign hi_load   = fall && (phase_q == PH_HI);
    assign byte_fire = fall && (phase_q == PH_LO) && !hold_rw && !hi_rw && (hold_rs == hi_rs);
    assign asm_byte  = {hi_d, hold_d};

`ifdef LCD_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;

    // An edge arriving on the expiry cycle is processed normally and suppresses the timeout.
    assign timeout_hit = (phase_q == PH_LO) && !fall && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if ((phase_q == PH_LO) && !fall && !timeout_hit) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_HI;
        end else begin
            phase_q <= phase_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_HI:   if (fall) phase_d = PH_LO;
            PH_LO:   if (fall || timeout_hit) phase_d = PH_HI;
            default: phase_d = PH_HI;
        endcase
    end

    always_comb begin
        nibble_phase = (phase_q == PH_LO);
        busy         = (busy_cnt != '0);
        lcd_d_oe     = oe_q;
        lcd_d_out    = 4'h0;
        if (oe_q && !hold_rs) begin
            lcd_d_out = (phase_q == PH_HI) ? {busy_cnt != '0, addr[6:4]} : addr[3:0];
        end
    end

    always_comb begin
        addr_nxt = addr;
        if (hi_rs) begin
            addr_nxt = addr + 7'd1;
        end else if (asm_byte == 8'h01) begin
            addr_nxt = 7'd0;
        end else if (asm_byte[7]) begin
            addr_nxt = asm_byte[6:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            oe_q       <= 1'b0;
            hold_rs    <= 1'b0;
            hold_rw    <= 1'b0;
            hold_d     <= 4'h0;
            hi_rs      <= 1'b0;
            hi_rw      <= 1'b0;
            hi_d       <= 4'h0;
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_data  <= 8'h00;
            addr       <= 7'd0;
            busy_cnt   <= '0;
        end else begin
            en_q       <= lcd_en;
            oe_q       <= lcd_en & lcd_rw;
            byte_valid <= byte_fire;
            if (lcd_en) begin
                hold_rs <= lcd_rs;
                hold_rw <= lcd_rw;
                hold_d  <= lcd_d_in;
            end
            if (hi_load) begin
                hi_rs <= hold_rs;
                hi_rw <= hold_rw;
                hi_d  <= hold_d;
            end
            // A write accepted while busy reloads the counter rather than waiting it out.
            if (byte_fire) begin
                byte_data <= asm_byte;
                byte_rs   <= hi_rs;
                addr      <= addr_nxt;
                busy_cnt  <= BUSY_W'(BUSY_CYCLES);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - BUSY_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Self-checking bench for lcd_nibble_rx: vector table of write bytes, byte scoreboard, hand-written corner sequences.
module tb_lcd_nibble_rx;

    localparam int BUSY = 40;
    localparam int NV   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [3:0] lcd_d_in;
    logic [3:0] lcd_d_out;
    logic       lcd_d_oe, byte_valid, byte_rs, busy, nibble_phase;
    logic [7:0] byte_data;
    logic [6:0] addr;
`ifdef LCD_RX_TIMEOUT_EN
    logic       timeout_err;
`endif

    always #5 clk = ~clk;

    lcd_nibble_rx #(
        .BUSY_CYCLES(BUSY)
`ifdef LCD_RX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_en(lcd_en),
        .lcd_d_in(lcd_d_in),
        .lcd_d_out(lcd_d_out),
        .lcd_d_oe(lcd_d_oe),
        .byte_valid(byte_valid),
        .byte_rs(byte_rs),
        .byte_data(byte_data),
        .busy(busy),
        .addr(addr),
        .nibble_phase(nibble_phase)
`ifdef LCD_RX_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [6:0] exp_addr;
    } vec_t;

    sb_t  sb[$];
    sb_t  mon_exp;
    vec_t vecs[NV];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every assembled byte must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_byte_valid", 32'(byte_valid), 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("sb_byte_data", 32'(byte_data), 32'(mon_exp.data));
                check("sb_byte_rs", 32'(byte_rs), 32'(mon_exp.rs));
            end
        end
    end

    // Called at a falling clock edge; returns at the falling edge after the transfer was processed.
    task automatic send_nibble(input logic rs, input logic rw, input logic [3:0] d);
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_d_in = d;
        lcd_en   = 1'b1;
        @(negedge clk);
        lcd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_byte(input logic rs, input logic [7:0] b);
        sb_t e;
        e.rs   = rs;
        e.data = b;
        send_nibble(rs, 1'b0, b[7:4]);
        sb.push_back(e);
        send_nibble(rs, 1'b0, b[3:0]);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic read_nibble(input logic rs, input logic [3:0] exp_d, input string tag);
        lcd_rs   = rs;
        lcd_rw   = 1'b1;
        lcd_d_in = 4'h0;
        lcd_en   = 1'b1;
        #1;
        check({tag, "_oe_lag"}, 32'(lcd_d_oe), 32'd0);
        @(negedge clk);
        check({tag, "_oe"}, 32'(lcd_d_oe), 32'd1);
        check({tag, "_d"}, 32'(lcd_d_out), 32'(exp_d));
        lcd_en = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_oe_off"}, 32'(lcd_d_oe), 32'd0);
        check({tag, "_d_off"}, 32'(lcd_d_out), 32'd0);
        lcd_rw = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_byte_rs"}, 32'(byte_rs), 32'd0);
        check({tag, "_byte_data"}, 32'(byte_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_phase"}, 32'(nibble_phase), 32'd0);
        check({tag, "_oe"}, 32'(lcd_d_oe), 32'd0);
        check({tag, "_d_out"}, 32'(lcd_d_out), 32'd0);
`ifdef LCD_RX_TIMEOUT_EN
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
`endif
    endtask

    task automatic measure_busy(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check(tag, 32'(n), 32'(BUSY));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{1'b0, 8'hFF, 7'h7F};
        vecs[1] = '{1'b1, 8'h41, 7'h00};
        vecs[2] = '{1'b1, 8'h42, 7'h01};
        vecs[3] = '{1'b1, 8'h43, 7'h02};
        vecs[4] = '{1'b0, 8'h01, 7'h00};
        vecs[5] = '{1'b1, 8'h7A, 7'h01};
        vecs[6] = '{1'b0, 8'h20, 7'h01};
        vecs[7] = '{1'b0, 8'hC7, 7'h47};
        vecs[8] = '{1'b1, 8'h00, 7'h48};
        vecs[9] = '{1'b0, 8'h81, 7'h01};

        rst      = 1'b1;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_en   = 1'b0;
        lcd_d_in = 4'h0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic command write, address set and busy window.
        write_byte(1'b0, 8'h85);
        check("w85_addr", 32'(addr), 32'h05);
        check("w85_phase", 32'(nibble_phase), 32'd0);
        measure_busy("w85_busy_len");

        // Status read while still busy after setting addr 0x25.
        write_byte(1'b0, 8'hA5);
        check("wA5_addr", 32'(addr), 32'h25);
        read_nibble(1'b0, 4'hA, "st_hi");
        read_nibble(1'b0, 4'h5, "st_lo");
        check("st_addr", 32'(addr), 32'h25);
        check("st_phase", 32'(nibble_phase), 32'd0);
        check("st_busy", 32'(busy), 32'd1);
        read_nibble(1'b1, 4'h0, "data_rd_hi");
        read_nibble(1'b1, 4'h0, "data_rd_lo");

        // Table of back-to-back writes, each accepted while busy.
        for (int i = 0; i < NV; i++) begin
            write_byte(vecs[i].rs, vecs[i].data);
            check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
        end
        measure_busy("reload_busy_len");

        // rs and rw mismatches drop the pair.
        send_nibble(1'b0, 1'b0, 4'h3);
        check("mis_rs_phase_lo", 32'(nibble_phase), 32'd1);
        send_nibble(1'b1, 1'b0, 4'h4);
        #1;
        check("mis_rs_valid", 32'(byte_valid), 32'd0);
        check("mis_rs_phase", 32'(nibble_phase), 32'd0);
        check("mis_rs_addr", 32'(addr), 32'h01);
        @(negedge clk);
        send_nibble(1'b0, 1'b0, 4'h2);
        send_nibble(1'b0, 1'b1, 4'h2);
        #1;
        check("mis_rw_valid", 32'(byte_valid), 32'd0);
        check("mis_rw_phase", 32'(nibble_phase), 32'd0);
        @(negedge clk);
        write_byte(1'b0, 8'h01);
        check("clear_addr", 32'(addr), 32'h00);

        // Reset mid-byte discards the pending HI nibble.
        @(negedge clk);
        write_byte(1'b0, 8'h9A);
        check("w9A_addr", 32'(addr), 32'h1A);
        @(negedge clk);
        send_nibble(1'b0, 1'b0, 4'hC);
        check("mid_phase_lo", 32'(nibble_phase), 32'd1);
        #2 rst = 1'b1;
        #1 check_idle("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        write_byte(1'b0, 8'h30);
        check("w30_addr", 32'(addr), 32'h00);
        repeat (3) @(negedge clk);
        check("w30_hold", 32'(byte_data), 32'h30);

`ifdef LCD_RX_TIMEOUT_EN
        // Lone HI nibble times out after 16 idle cycles in LO phase.
        write_byte(1'b0, 8'h8A);
        check("w8A_addr", 32'(addr), 32'h0A);
        @(negedge clk);
        send_nibble(1'b0, 1'b0, 4'h8);
        #1;
        check("to_phase_lo", 32'(nibble_phase), 32'd1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("to_delay", 32'(n), 32'd16);
        check("to_phase_hi", 32'(nibble_phase), 32'd0);
        @(negedge clk);
        #1;
        check("to_pulse_end", 32'(timeout_err), 32'd0);
        @(negedge clk);
        write_byte(1'b0, 8'h80);
        check("w80_addr", 32'(addr), 32'h00);

        // LO edge on the expiry cycle wins over the timeout.
        @(negedge clk);
        write_byte(1'b0, 8'h9B);
        @(negedge clk);
        send_nibble(1'b0, 1'b0, 4'h8);
        sb.push_back('{1'b0, 8'h85});
        repeat (14) @(negedge clk);
        send_nibble(1'b0, 1'b0, 4'h5);
        #1;
        check("race_no_timeout", 32'(timeout_err), 32'd0);
        check("race_addr", 32'(addr), 32'h05);
        check("race_phase", 32'(nibble_phase), 32'd0);
        @(negedge clk);
        #1;
        check("race_no_timeout_late", 32'(timeout_err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
